// File: rtl/r2n_buffer_if.sv
// Stream bundle for the ready-to-normal reshaper: blocked beats in, full matrix rows out.
interface r2n_buffer_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK_SIZE = 4,
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned ROW        = 8,
  parameter int unsigned COL        = 4
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_data;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [WIDTH*COL-1:0]                  out_data;
  logic [$clog2(ROW)-1:0]                out_row_idx;
  logic                                  out_last;
  logic                                  done;

  // Producer of beats and consumer of rows.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row_idx, out_last, done
  );

  // The reshaper itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row_idx, out_last, done
  );
endinterface

// File: rtl/r2n_buffer.sv
// Ready-to-normal reshaper: collects NUM_CORES blocks per beat into a slice of full rows held
// in one of two ping-pong banks, then emits the slice row by row while the other bank fills.
module r2n_buffer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned BLOCK_SIZE = 2,
  parameter int unsigned CHUNK_SIZE = 4,
  parameter int unsigned ROW        = 8,
  parameter int unsigned COL        = 4,
  parameter int unsigned NUM_CORES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  r2n_buffer_if.slave bus
);
  localparam int unsigned SliceRows = BLOCK_SIZE * NUM_CORES;
  localparam int unsigned Beats     = COL / BLOCK_SIZE;
  localparam int unsigned Slices    = ROW / SliceRows;
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned RowW      = (SliceRows > 1) ? $clog2(SliceRows) : 1;
  localparam int unsigned SliceW    = (Slices > 1) ? $clog2(Slices) : 1;
  localparam int unsigned ColW      = (COL > 1) ? $clog2(COL) : 1;
  localparam int unsigned IdxW      = (ROW > 1) ? $clog2(ROW) : 1;

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkDraining} bank_st_e;

  bank_st_e             bank_st_q [2];
  bank_st_e             bank_st_d [2];
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [BeatW-1:0]     beat_q, beat_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [SliceW-1:0]    slice_q, slice_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [WIDTH*COL-1:0] out_data_q, out_data_d;
  logic [IdxW-1:0]      out_row_idx_q, out_row_idx_d;

  // Slice storage, indexed [bank][slice row][column]; never cleared.
  logic [WIDTH-1:0]     mem_q [2][SliceRows][COL];

  logic                 in_ready;
  logic                 in_hs;
  logic                 wr_last;
  logic                 out_hs;
  logic                 final_hs;
  logic                 start;
  logic                 step;
  logic                 cand_bank;
  logic                 sel_bank;
  logic [RowW-1:0]      sel_row;
  logic [SliceW-1:0]    slice_nxt;
  logic [WIDTH*COL-1:0] row_vec;

  // Write side: accept while the current write bank still has room; advance beat and bank.
  always_comb begin
    in_ready  = (bank_st_q[wr_bank_q] == BkEmpty) || (bank_st_q[wr_bank_q] == BkFilling);
    in_hs     = bus.in_valid && in_ready;
    wr_last   = (beat_q == BeatW'(Beats - 1));
    beat_d    = beat_q;
    wr_bank_d = wr_bank_q;
    if (in_hs) begin
      if (wr_last) begin
        beat_d    = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // Read side: start a slice when idle (or right as the previous one finishes), else step rows.
  always_comb begin
    out_hs    = out_valid_q && bus.out_ready;
    final_hs  = out_hs && out_last_q;
    cand_bank = final_hs ? ~rd_bank_q : rd_bank_q;
    slice_nxt = slice_q;
    if (final_hs) begin
      slice_nxt = (slice_q == SliceW'(Slices - 1)) ? '0 : slice_q + 1'b1;
    end
    start     = (!out_valid_q || final_hs) && (bank_st_q[cand_bank] == BkFull);
    step      = out_hs && !out_last_q;
    sel_bank  = start ? cand_bank : rd_bank_q;
    sel_row   = start ? '0 : row_q + 1'b1;

    row_vec = '0;
    for (int c = 0; c < COL; c++) begin
      row_vec[(COL-1-c)*WIDTH +: WIDTH] = mem_q[sel_bank][sel_row][ColW'(c)];
    end

    rd_bank_d     = cand_bank;
    slice_d       = slice_nxt;
    row_d         = row_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_data_d    = out_data_q;
    out_row_idx_d = out_row_idx_q;
    if (start || step) begin
      row_d       = sel_row;
      out_valid_d = 1'b1;
      out_data_d  = row_vec;
      out_last_d  = (sel_row == RowW'(SliceRows - 1));
      out_row_idx_d = start ? IdxW'(32'(slice_nxt) * SliceRows) : out_row_idx_q + 1'b1;
    end else if (final_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_d[b] = bank_st_q[b];
      case (bank_st_q[b])
        BkEmpty: begin
          if (in_hs && (wr_bank_q == 1'(b))) bank_st_d[b] = wr_last ? BkFull : BkFilling;
        end
        BkFilling: begin
          if (in_hs && (wr_bank_q == 1'(b)) && wr_last) bank_st_d[b] = BkFull;
        end
        BkFull: begin
          if (start && (cand_bank == 1'(b))) bank_st_d[b] = BkDraining;
        end
        BkDraining: begin
          if (final_hs && (rd_bank_q == 1'(b))) bank_st_d[b] = BkEmpty;
        end
        default: bank_st_d[b] = BkEmpty;
      endcase
    end
  end

  // Bank state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) bank_st_q[b] <= BkEmpty;
    end else begin
      for (int b = 0; b < 2; b++) bank_st_q[b] <= bank_st_d[b];
    end
  end

  // Counters, bank pointers and registered output row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      beat_q        <= '0;
      row_q         <= '0;
      slice_q       <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      out_row_idx_q <= '0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      beat_q        <= beat_d;
      row_q         <= row_d;
      slice_q       <= slice_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_data_q    <= out_data_d;
      out_row_idx_q <= out_row_idx_d;
    end
  end

  // Scatter each block element (r,c) of core k into its slice row and column.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        for (int r = 0; r < BLOCK_SIZE; r++) begin
          for (int c = 0; c < BLOCK_SIZE; c++) begin
            mem_q[wr_bank_q][RowW'(k*BLOCK_SIZE + r)][ColW'(32'(beat_q)*BLOCK_SIZE + c)] <=
              bus.in_data[((NUM_CORES-1-k)*CHUNK_SIZE + CHUNK_SIZE-1-(r*BLOCK_SIZE+c))*WIDTH
                          +: WIDTH];
          end
        end
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_row_idx = out_row_idx_q;
  assign bus.out_last    = out_last_q;
  assign bus.done        = out_hs && (out_row_idx_q == IdxW'(ROW - 1));
endmodule
